// File: rtl/multi_alarm_handler_if.sv
// Bus bundle for multi_alarm_handler. It carries the time inputs, the slot
// configuration port, the snooze/dismiss controls and the alarm status outputs.
interface multi_alarm_handler_if #(
  parameter int unsigned NUM_ALARMS = 4,
  parameter int unsigned IDX_W      = 2
);
  logic                  tick;
  logic [7:0]            cur_hour;
  logic [7:0]            cur_min;
  logic [7:0]            cur_sec;
  logic                  cfg_we;
  logic [IDX_W-1:0]      cfg_idx;
  logic [7:0]            cfg_hour;
  logic [7:0]            cfg_min;
  logic [7:0]            cfg_sec;
  logic                  cfg_en;
  logic                  snooze;
  logic                  dismiss;
  logic                  alarm_sound;
  logic [IDX_W-1:0]      active_idx;
  logic [NUM_ALARMS-1:0] ringing;
  logic [NUM_ALARMS-1:0] snoozed;
  logic                  cfg_err;

  // Drives time, configuration and controls; observes alarm status.
  modport master (
    output tick, cur_hour, cur_min, cur_sec,
    output cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_sec, cfg_en,
    output snooze, dismiss,
    input  alarm_sound, active_idx, ringing, snoozed, cfg_err
  );

  // The alarm engine itself.
  modport slave (
    input  tick, cur_hour, cur_min, cur_sec,
    input  cfg_we, cfg_idx, cfg_hour, cfg_min, cfg_sec, cfg_en,
    input  snooze, dismiss,
    output alarm_sound, active_idx, ringing, snoozed, cfg_err
  );
endinterface

// File: rtl/multi_alarm_handler.sv
// N-slot alarm engine. Each slot has a programmable time and enable and a small
// IDLE/RINGING/SNOOZED state machine with timed auto-silence and snooze re-ring.
module multi_alarm_handler #(
  parameter int unsigned NUM_ALARMS  = 4,
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300
) (
  input logic                  clk,
  input logic                  reset,
  multi_alarm_handler_if.slave bus
);

  localparam int unsigned MaxSecs = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
  localparam int unsigned CntW    = $clog2(MaxSecs + 1);
  localparam logic [CntW-1:0] RingLoad = CntW'(RING_SECS);
  localparam logic [CntW-1:0] SnzLoad  = CntW'(SNOOZE_SECS);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);

  typedef enum logic [1:0] {StIdle, StRinging, StSnoozed} slot_state_e;

  // Slot configuration
  logic [7:0]            hour_q [NUM_ALARMS];
  logic [7:0]            min_q  [NUM_ALARMS];
  logic [7:0]            sec_q  [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] en_q;

  // Slot state. One counter per slot serves as ring or snooze countdown,
  // since a slot is never in both states at once.
  slot_state_e           state_q [NUM_ALARMS];
  slot_state_e           state_d [NUM_ALARMS];
  logic [CntW-1:0]       cnt_q   [NUM_ALARMS];
  logic [CntW-1:0]       cnt_d   [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match_q;
  logic [NUM_ALARMS-1:0] match_d;
  logic                  cfg_err_q;

  logic                  cfg_ok;
  logic [NUM_ALARMS-1:0] cfg_hit;
  logic [NUM_ALARMS-1:0] cur_match;
  logic [NUM_ALARMS-1:0] ring_vec;
  logic [NUM_ALARMS-1:0] snz_vec;
  logic [IDX_W-1:0]      active_idx;
  logic                  found;

  // A write is accepted only for an existing slot and a legal 24-hour time.
  assign cfg_ok = bus.cfg_we && (32'(bus.cfg_idx) < NUM_ALARMS) &&
                  (bus.cfg_hour <= 8'd23) && (bus.cfg_min <= 8'd59) && (bus.cfg_sec <= 8'd59);

  // Per-slot decode of the config target, time compare and status vectors.
  always_comb begin
    cfg_hit   = '0;
    cur_match = '0;
    ring_vec  = '0;
    snz_vec   = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      cfg_hit[i]   = cfg_ok && (bus.cfg_idx == IDX_W'(i));
      cur_match[i] = (bus.cur_hour == hour_q[i]) && (bus.cur_min == min_q[i]) &&
                     (bus.cur_sec == sec_q[i]);
      ring_vec[i]  = (state_q[i] == StRinging);
      snz_vec[i]   = (state_q[i] == StSnoozed);
    end
  end

  // Lowest-index ringing slot, 0 when nothing rings.
  always_comb begin
    active_idx = '0;
    found      = 1'b0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (ring_vec[i] && !found) begin
        active_idx = IDX_W'(i);
        found      = 1'b1;
      end
    end
  end

  // Slot next-state: dismiss > snooze > config write > tick.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      match_d[i] = match_q[i];

      if (bus.dismiss) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
      end else if (bus.snooze && ring_vec[i] && (active_idx == IDX_W'(i))) begin
        state_d[i] = StSnoozed;
        cnt_d[i]   = SnzLoad;
      end else if (cfg_hit[i]) begin
        state_d[i] = StIdle;
        cnt_d[i]   = '0;
      end else if (bus.tick) begin
        case (state_q[i])
          StIdle: begin
            if (en_q[i] && cur_match[i] && !match_q[i]) begin
              state_d[i] = StRinging;
              cnt_d[i]   = RingLoad;
            end
          end
          StRinging: begin
            if (cnt_q[i] == CntOne) begin
              state_d[i] = StIdle;
              cnt_d[i]   = '0;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
          StSnoozed: begin
            if (cnt_q[i] == CntOne) begin
              state_d[i] = StRinging;
              cnt_d[i]   = RingLoad;
            end else begin
              cnt_d[i] = cnt_q[i] - CntOne;
            end
          end
          default: begin
            state_d[i] = StIdle;
            cnt_d[i]   = '0;
          end
        endcase
      end

      // Match history is sampled per second, so a held or repeated time only
      // fires once; a fresh write clears it so the new time fires on next tick.
      if (cfg_hit[i]) begin
        match_d[i] = 1'b0;
      end else if (bus.tick) begin
        match_d[i] = cur_match[i];
      end
    end
  end

  // Slot state, counters and match history.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        state_q[i] <= StIdle;
        cnt_q[i]   <= '0;
      end
      match_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      match_q <= match_d;
    end
  end

  // Slot configuration registers and the rejected-write pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        hour_q[i] <= '0;
        min_q[i]  <= '0;
        sec_q[i]  <= '0;
      end
      en_q      <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (cfg_hit[i]) begin
          hour_q[i] <= bus.cfg_hour;
          min_q[i]  <= bus.cfg_min;
          sec_q[i]  <= bus.cfg_sec;
          en_q[i]   <= bus.cfg_en;
        end
      end
      cfg_err_q <= bus.cfg_we && !cfg_ok;
    end
  end

  assign bus.ringing     = ring_vec;
  assign bus.snoozed     = snz_vec;
  assign bus.alarm_sound = |ring_vec;
  assign bus.active_idx  = active_idx;
  assign bus.cfg_err     = cfg_err_q;

endmodule

// File: tb/tb_multi_alarm_handler.sv
// Bench for multi_alarm_handler: directed scenarios followed by random traffic,
// all outputs compared every cycle against a seconds-of-day reference model.
module tb_multi_alarm_handler;

  localparam int NumAlarms  = 5;
  localparam int IdxW       = 3;
  localparam int RingSecs   = 60;
  localparam int SnoozeSecs = 300;
  localparam int MIdle = 0, MRing = 1, MSnz = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  multi_alarm_handler_if #(.NUM_ALARMS(NumAlarms), .IDX_W(IdxW)) bus ();

  multi_alarm_handler #(
    .NUM_ALARMS (NumAlarms),
    .IDX_W      (IdxW),
    .RING_SECS  (RingSecs),
    .SNOOZE_SECS(SnoozeSecs)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Reference model: slot time kept as seconds of day, countdown as seconds left
  int m_state [NumAlarms];
  int m_left  [NumAlarms];
  int m_time  [NumAlarms];
  bit m_en    [NumAlarms];
  bit m_seen  [NumAlarms];
  bit m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lowest_ringing();
    for (int i = 0; i < NumAlarms; i++) if (m_state[i] == MRing) return i;
    return -1;
  endfunction

  function automatic logic [31:0] exp_vec(input int st);
    logic [31:0] v = '0;
    for (int i = 0; i < NumAlarms; i++) v[i] = (m_state[i] == st);
    return v;
  endfunction

  task automatic model_step();
    int act, idx, cur_t;
    bit ok;
    int nstate [NumAlarms];
    int nleft  [NumAlarms];
    if (!reset) begin
      for (int i = 0; i < NumAlarms; i++) begin
        m_state[i] = MIdle; m_left[i] = 0; m_time[i] = 0; m_en[i] = 0; m_seen[i] = 0;
      end
      m_err = 0;
      return;
    end
    act   = lowest_ringing();
    idx   = int'(bus.cfg_idx);
    ok    = bus.cfg_we && idx < NumAlarms && bus.cfg_hour <= 23 && bus.cfg_min <= 59 &&
            bus.cfg_sec <= 59;
    cur_t = int'(bus.cur_hour) * 3600 + int'(bus.cur_min) * 60 + int'(bus.cur_sec);
    for (int i = 0; i < NumAlarms; i++) begin
      nstate[i] = m_state[i];
      nleft[i]  = m_left[i];
      if (bus.dismiss) begin
        nstate[i] = MIdle; nleft[i] = 0;
      end else if (bus.snooze && act == i) begin
        nstate[i] = MSnz; nleft[i] = SnoozeSecs;
      end else if (ok && idx == i) begin
        nstate[i] = MIdle; nleft[i] = 0;
      end else if (bus.tick) begin
        if (m_state[i] == MIdle) begin
          if (m_en[i] && cur_t == m_time[i] && !m_seen[i]) begin
            nstate[i] = MRing; nleft[i] = RingSecs;
          end
        end else begin
          nleft[i] = m_left[i] - 1;
          if (nleft[i] == 0) begin
            if (m_state[i] == MRing) nstate[i] = MIdle;
            else begin nstate[i] = MRing; nleft[i] = RingSecs; end
          end
        end
      end
    end
    for (int i = 0; i < NumAlarms; i++) begin
      if (ok && idx == i) m_seen[i] = 0;
      else if (bus.tick) m_seen[i] = (cur_t == m_time[i]);
      m_state[i] = nstate[i];
      m_left[i]  = nleft[i];
      if (ok && idx == i) begin
        m_time[i] = int'(bus.cfg_hour) * 3600 + int'(bus.cfg_min) * 60 + int'(bus.cfg_sec);
        m_en[i]   = bus.cfg_en;
      end
    end
    m_err = bus.cfg_we && !ok;
  endtask

  // One clock: model follows the edge, all outputs compared 1 time unit later.
  task automatic cycle();
    int act;
    @(posedge clk);
    model_step();
    #1;
    act = lowest_ringing();
    check_eq("ringing", 32'(bus.ringing), exp_vec(MRing));
    check_eq("snoozed", 32'(bus.snoozed), exp_vec(MSnz));
    check_eq("alarm_sound", 32'(bus.alarm_sound), 32'(act >= 0));
    check_eq("active_idx", 32'(bus.active_idx), (act >= 0) ? 32'(act) : 32'd0);
    check_eq("cfg_err", 32'(bus.cfg_err), 32'(m_err));
    bus.tick = 0; bus.cfg_we = 0; bus.snooze = 0; bus.dismiss = 0;
  endtask

  task automatic set_cur(input int t);
    bus.cur_hour = 8'(t / 3600);
    bus.cur_min  = 8'((t / 60) % 60);
    bus.cur_sec  = 8'(t % 60);
  endtask

  task automatic cfg_write(input int idx, input int h, input int m, input int s, input bit en);
    bus.cfg_we = 1; bus.cfg_idx = IdxW'(idx);
    bus.cfg_hour = 8'(h); bus.cfg_min = 8'(m); bus.cfg_sec = 8'(s); bus.cfg_en = en;
    cycle();
  endtask

  task automatic tick_n(input int n);
    for (int k = 0; k < n; k++) begin
      bus.tick = 1;
      cycle();
      cycle();
    end
  endtask

  int pool [4] = '{7 * 3600, 12 * 3600 + 30 * 60, 23 * 3600 + 59 * 60 + 59, 0};
  int cur_t;

  initial begin
    bus.tick = 0; bus.cfg_we = 0; bus.cfg_idx = '0; bus.cfg_hour = 0; bus.cfg_min = 0;
    bus.cfg_sec = 0; bus.cfg_en = 0; bus.snooze = 0; bus.dismiss = 0;
    set_cur(0);

    // Reset, all outputs low
    reset = 0;
    cycle();
    cycle();
    check_eq("reset_ringing", 32'(bus.ringing), 32'd0);
    check_eq("reset_sound", 32'(bus.alarm_sound), 32'd0);
    reset = 1;
    cycle();

    // Slot 0 at 07:00:00 fires one cycle after the matching tick
    set_cur(6 * 3600 + 59 * 60 + 59);
    cfg_write(0, 7, 0, 0, 1);
    bus.tick = 1;
    cycle();
    set_cur(7 * 3600);
    bus.tick = 1;
    cycle();
    check_eq("fire_ringing", 32'(bus.ringing), 32'h01);
    check_eq("fire_sound", 32'(bus.alarm_sound), 32'd1);

    // Auto-silence exactly on the 60th tick, held time does not re-trigger
    tick_n(RingSecs - 1);
    check_eq("ring_59", 32'(bus.ringing[0]), 32'd1);
    tick_n(1);
    check_eq("ring_60", 32'(bus.ringing[0]), 32'd0);
    tick_n(5);
    check_eq("held_no_retrigger", 32'(bus.ringing), 32'd0);

    // Snooze and re-ring after 300 ticks
    cfg_write(0, 7, 0, 0, 1);
    bus.tick = 1;
    cycle();
    check_eq("refire", 32'(bus.ringing), 32'h01);
    bus.snooze = 1;
    cycle();
    check_eq("snooze_state", 32'(bus.snoozed), 32'h01);
    check_eq("snooze_sound", 32'(bus.alarm_sound), 32'd0);
    tick_n(SnoozeSecs - 1);
    check_eq("snooze_299", 32'(bus.snoozed), 32'h01);
    tick_n(1);
    check_eq("rering", 32'(bus.ringing), 32'h01);
    bus.dismiss = 1;
    cycle();
    check_eq("dismiss0", 32'(bus.ringing), 32'd0);

    // Two slots together, snooze walks active_idx, dismiss clears all
    set_cur(12 * 3600 + 29 * 60 + 59);
    cfg_write(1, 12, 30, 0, 1);
    cfg_write(3, 12, 30, 0, 1);
    bus.tick = 1;
    cycle();
    set_cur(12 * 3600 + 30 * 60);
    bus.tick = 1;
    cycle();
    check_eq("dual_ringing", 32'(bus.ringing), 32'h0a);
    check_eq("dual_active", 32'(bus.active_idx), 32'd1);
    bus.snooze = 1;
    cycle();
    check_eq("dual_active_after", 32'(bus.active_idx), 32'd3);
    check_eq("dual_snoozed", 32'(bus.snoozed), 32'h02);
    bus.dismiss = 1;
    cycle();
    check_eq("dual_dismiss_r", 32'(bus.ringing), 32'd0);
    check_eq("dual_dismiss_s", 32'(bus.snoozed), 32'd0);

    // Rejected writes pulse cfg_err and leave the slot alone
    set_cur(9 * 3600 + 59 * 60 + 59);
    cfg_write(2, 10, 0, 0, 1);
    cfg_write(2, 24, 0, 0, 1);
    check_eq("err_hour", 32'(bus.cfg_err), 32'd1);
    cycle();
    check_eq("err_pulse_end", 32'(bus.cfg_err), 32'd0);
    cfg_write(NumAlarms, 10, 0, 0, 0);
    check_eq("err_idx", 32'(bus.cfg_err), 32'd1);
    bus.tick = 1;
    cycle();
    set_cur(10 * 3600);
    bus.tick = 1;
    cycle();
    check_eq("slot2_kept", 32'(bus.ringing), 32'h04);

    // Reset mid-snooze, nothing resumes afterwards
    bus.snooze = 1;
    cycle();
    check_eq("slot2_snoozed", 32'(bus.snoozed), 32'h04);
    tick_n(150);
    reset = 0;
    cycle();
    check_eq("midreset_snoozed", 32'(bus.snoozed), 32'd0);
    check_eq("midreset_ringing", 32'(bus.ringing), 32'd0);
    reset = 1;
    tick_n(5);
    set_cur(9 * 3600 + 59 * 60 + 59);
    tick_n(1);
    set_cur(10 * 3600);
    tick_n(1);
    check_eq("no_rering", 32'(bus.ringing), 32'd0);

    // Random traffic against the model
    cur_t = pool[0] - 2;
    for (int n = 0; n < 12000; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r == 6 || r == 7) cur_t = (cur_t + 1) % 86400;
      else if (r == 8) cur_t = (pool[$urandom_range(0, 3)] + 86399) % 86400;
      else if (r == 9) cur_t = pool[$urandom_range(0, 3)];
      set_cur(cur_t);
      bus.tick    = ($urandom_range(0, 1) == 0);
      bus.snooze  = ($urandom_range(0, 19) == 0);
      bus.dismiss = ($urandom_range(0, 699) == 0);
      reset       = ($urandom_range(0, 2999) != 0);
      if ($urandom_range(0, 29) == 0) begin
        int t;
        t = pool[$urandom_range(0, 3)];
        bus.cfg_we   = 1;
        bus.cfg_idx  = IdxW'($urandom_range(0, 6));
        bus.cfg_hour = 8'(t / 3600);
        bus.cfg_min  = 8'((t / 60) % 60);
        bus.cfg_sec  = 8'(t % 60);
        bus.cfg_en   = ($urandom_range(0, 3) != 0);
        case ($urandom_range(0, 7))
          0: bus.cfg_hour = 8'($urandom_range(24, 255));
          1: bus.cfg_min  = 8'($urandom_range(60, 255));
          2: bus.cfg_sec  = 8'($urandom_range(60, 255));
          default: ;
        endcase
      end
      cycle();
    end
    reset = 1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
